// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, optional
// write-to-read bypass, and a per-register busy scoreboard for RAW hazard detection.
module regfile_sb #(
    parameter int WIDTH  = 16,
    parameter int AW     = 3,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 write,
    input  logic [AW-1:0]        writenum,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 lock,
    input  logic [AW-1:0]        locknum,
    input  logic                 flush,
    input  logic [AW-1:0]        anum,
    input  logic [AW-1:0]        bnum,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic                 a_busy,
    output logic                 b_busy,
    output logic [2**AW-1:0]     busy_vec,
    output logic                 hazard
);

    localparam int unsigned NREGS = 2**AW;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             byp_a;
    logic             byp_b;

    always_comb begin
        regs_d = regs_q;
        if (write) begin
            regs_d[writenum] = data_in;
        end
    end

    // Lock is applied after the writeback clear so a new producer wins a same-index collision.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (write) begin
                busy_d[writenum] = 1'b0;
            end
            if (lock) begin
                busy_d[locknum] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        byp_a  = (BYPASS != 0) && write && (writenum == anum);
        byp_b  = (BYPASS != 0) && write && (writenum == bnum);
        a_out  = byp_a ? data_in : regs_q[anum];
        b_out  = byp_b ? data_in : regs_q[bnum];
        a_busy = byp_a ? 1'b0 : busy_q[anum];
        b_busy = byp_b ? 1'b0 : busy_q[bnum];
        hazard = a_busy | b_busy;
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: three instances (bypass on, bypass off,
// 32-bit x 16 registers) checked against an array-based reference model.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Shared stimulus for the two 16x8 instances
    logic        write, lock, flush;
    logic [2:0]  writenum, locknum, anum, bnum;
    logic [15:0] data_in;
    // Stimulus for the 32x16 instance
    logic        write2, lock2, flush2;
    logic [3:0]  wn2, ln2, an2, bn2;
    logic [31:0] din2;

    logic [15:0] a0, b0, a1, b1;
    logic        ab0, bb0, hz0, ab1, bb1, hz1;
    logic [7:0]  bv0, bv1;
    logic [31:0] a2, b2;
    logic        ab2, bb2, hz2;
    logic [15:0] bv2;

    regfile_sb #(.WIDTH(16), .AW(3), .BYPASS(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum), .data_in(data_in),
        .lock(lock), .locknum(locknum), .flush(flush), .anum(anum), .bnum(bnum),
        .a_out(a0), .b_out(b0), .a_busy(ab0), .b_busy(bb0), .busy_vec(bv0), .hazard(hz0));

    regfile_sb #(.WIDTH(16), .AW(3), .BYPASS(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum), .data_in(data_in),
        .lock(lock), .locknum(locknum), .flush(flush), .anum(anum), .bnum(bnum),
        .a_out(a1), .b_out(b1), .a_busy(ab1), .b_busy(bb1), .busy_vec(bv1), .hazard(hz1));

    regfile_sb #(.WIDTH(32), .AW(4), .BYPASS(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .write(write2), .writenum(wn2), .data_in(din2),
        .lock(lock2), .locknum(ln2), .flush(flush2), .anum(an2), .bnum(bn2),
        .a_out(a2), .b_out(b2), .a_busy(ab2), .b_busy(bb2), .busy_vec(bv2), .hazard(hz2));

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        ab;
        logic        bb;
        logic        hz;
        logic [15:0] bv;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain arrays of register contents and busy flags per instance
    logic [31:0] mreg  [3][16];
    logic        mbusy [3][16];

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, id, $time, got, exp);
        end
    endtask

    // Monitor: whenever the stimulus presents a settled input vector, compare all queued expectations
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.id)
                    0: begin
                        chk("a_out", 0, {16'h0, a0}, e.a);  chk("b_out", 0, {16'h0, b0}, e.b);
                        chk("a_busy", 0, {31'h0, ab0}, {31'h0, e.ab});
                        chk("b_busy", 0, {31'h0, bb0}, {31'h0, e.bb});
                        chk("hazard", 0, {31'h0, hz0}, {31'h0, e.hz});
                        chk("busy_vec", 0, {24'h0, bv0}, {16'h0, e.bv});
                    end
                    1: begin
                        chk("a_out", 1, {16'h0, a1}, e.a);  chk("b_out", 1, {16'h0, b1}, e.b);
                        chk("a_busy", 1, {31'h0, ab1}, {31'h0, e.ab});
                        chk("b_busy", 1, {31'h0, bb1}, {31'h0, e.bb});
                        chk("hazard", 1, {31'h0, hz1}, {31'h0, e.hz});
                        chk("busy_vec", 1, {24'h0, bv1}, {16'h0, e.bv});
                    end
                    default: begin
                        chk("a_out", 2, a2, e.a);  chk("b_out", 2, b2, e.b);
                        chk("a_busy", 2, {31'h0, ab2}, {31'h0, e.ab});
                        chk("b_busy", 2, {31'h0, bb2}, {31'h0, e.bb});
                        chk("hazard", 2, {31'h0, hz2}, {31'h0, e.hz});
                        chk("busy_vec", 2, {16'h0, bv2}, e.bv);
                    end
                endcase
            end
        end
    end

    task automatic clear_model();
        for (int id = 0; id < 3; id++)
            for (int i = 0; i < 16; i++) begin
                mreg[id][i]  = '0;
                mbusy[id][i] = 1'b0;
            end
    endtask

    // Called just after a falling edge once inputs are set: checks the current
    // combinational view, then advances the model across the coming rising edge.
    task automatic cycle();
        exp_t e;
        logic        w, lk, fl, byp_a, byp_b;
        logic [3:0]  wn, ln, an, bn;
        logic [31:0] din;
        int          n;
        #1;
        if (!reset_n) clear_model();
        for (int id = 0; id < 3; id++) begin
            if (id < 2) begin
                w = write; lk = lock; fl = flush; din = {16'h0, data_in};
                wn = {1'b0, writenum}; ln = {1'b0, locknum}; an = {1'b0, anum}; bn = {1'b0, bnum};
                n = 8;
            end else begin
                w = write2; lk = lock2; fl = flush2; din = din2;
                wn = wn2; ln = ln2; an = an2; bn = bn2;
                n = 16;
            end
            byp_a = (id != 1) && w && (wn == an);
            byp_b = (id != 1) && w && (wn == bn);
            e.id = id;
            e.a  = byp_a ? din : mreg[id][an];
            e.b  = byp_b ? din : mreg[id][bn];
            e.ab = byp_a ? 1'b0 : mbusy[id][an];
            e.bb = byp_b ? 1'b0 : mbusy[id][bn];
            e.hz = e.ab | e.bb;
            e.bv = '0;
            for (int i = 0; i < n; i++) e.bv[i] = mbusy[id][i];
            q.push_back(e);
            if (reset_n) begin
                if (w) mreg[id][wn] = din;
                for (int i = 0; i < n; i++) begin
                    if (fl)                 mbusy[id][i] = 1'b0;
                    else if (lk && ln == i) mbusy[id][i] = 1'b1;
                    else if (w && wn == i)  mbusy[id][i] = 1'b0;
                end
            end
        end
        ->sample_ev;
        @(negedge clk);
    endtask

    task automatic idle();
        write = 0; lock = 0; flush = 0; writenum = 0; locknum = 0; anum = 0; bnum = 0; data_in = 0;
        write2 = 0; lock2 = 0; flush2 = 0; wn2 = 0; ln2 = 0; an2 = 0; bn2 = 0; din2 = 0;
    endtask

    initial begin
        reset_n = 1'b1;
        idle();
        clear_model();
        @(negedge clk);
        // Populate and lock so the asynchronous reset has state to discard
        write = 1; writenum = 5; data_in = 16'h1234; lock = 1; locknum = 7;
        write2 = 1; wn2 = 9; din2 = 32'hCAFE0001; lock2 = 1; ln2 = 3;
        cycle();
        idle();
        #2 reset_n = 1'b0;   // asserted between edges
        anum = 5; bnum = 7; an2 = 9; bn2 = 3;
        cycle();
        reset_n = 1'b1;
        cycle();

        for (int i = 0; i < 8; i++) begin
            idle(); write = 1; writenum = 3'(i); data_in = 16'(16'h1111 * i);
            anum = 3'(i); bnum = 3'(7 - i);
            cycle();
        end
        for (int i = 0; i < 8; i++) begin
            idle(); anum = 3'(i); bnum = 3'(7 - i);
            cycle();
        end

        idle(); write = 1; writenum = 3; data_in = 16'hAAAA; cycle();
        idle(); write = 1; writenum = 3; data_in = 16'h5A5A; anum = 3; cycle();
        idle(); anum = 3; cycle();

        idle(); lock = 1; locknum = 2; cycle();
        idle(); anum = 2; cycle();
        idle(); write = 1; writenum = 2; data_in = 16'h0042; anum = 2; cycle();
        idle(); anum = 2; bnum = 2; cycle();

        idle(); lock = 1; locknum = 4; write = 1; writenum = 4; data_in = 16'h00FF; cycle();
        idle(); anum = 4; cycle();

        idle(); lock = 1; locknum = 1; cycle();
        idle(); lock = 1; locknum = 6; cycle();
        idle(); lock = 1; locknum = 7; anum = 6; bnum = 1; cycle();
        idle(); flush = 1; lock = 1; locknum = 3; write = 1; writenum = 1; data_in = 16'h0009; cycle();
        idle(); anum = 1; bnum = 7; cycle();

        idle(); write2 = 1; wn2 = 15; din2 = 32'hDEADBEEF; cycle();
        idle(); bn2 = 15; an2 = 0; cycle();
        idle(); lock2 = 1; ln2 = 15; cycle();
        idle(); bn2 = 15; cycle();

        for (int k = 0; k < 400; k++) begin
            write = 1'($urandom); writenum = 3'($urandom); data_in = 16'($urandom);
            lock = 1'($urandom); locknum = 3'($urandom); flush = ($urandom_range(15) == 0);
            anum = 3'($urandom); bnum = 3'($urandom);
            if ($urandom_range(3) == 0) anum = writenum;
            write2 = 1'($urandom); wn2 = 4'($urandom); din2 = $urandom;
            lock2 = 1'($urandom); ln2 = 4'($urandom); flush2 = ($urandom_range(15) == 0);
            an2 = 4'($urandom); bn2 = 4'($urandom);
            if ($urandom_range(3) == 0) bn2 = wn2;
            reset_n = ($urandom_range(63) != 0);
            cycle();
            reset_n = 1'b1;
        end

        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the Simple RISC Machine 8x16 register file. It provides one write/writeback port and two combinational read ports, with optional write-to-read bypass. A per-register busy scoreboard tracks in-flight results so the controller FSM can detect read-after-write hazards. It sits between the datapath writeback mux and the A/B operand latches, and feeds its hazard status to the controller.

Parameters:
WIDTH, 16, data width of each register.
AW, 3, register address width; register count NREGS = 2**AW.
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value only.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
write  input  1  writeback enable.
writenum  input  AW  writeback register index.
data_in  input  WIDTH  writeback data.
lock  input  1  mark register locknum busy (result in flight).
locknum  input  AW  register index to lock.
flush  input  1  synchronous clear of all busy bits; register contents unaffected.
anum  input  AW  read port A index.
bnum  input  AW  read port B index.
a_out  output  WIDTH  read data A (combinational).
b_out  output  WIDTH  read data B (combinational).
a_busy  output  1  register anum has a pending result.
b_busy  output  1  register bnum has a pending result.
busy_vec  output  NREGS  registered scoreboard; bit i = register i busy.
hazard  output  1  a_busy | b_busy.

Behaviour:
- Reset (reset_n=0, async): all NREGS registers = 0, busy_vec = 0. Outputs follow combinationally: a_out = b_out = 0 (unless bypassing data_in with BYPASS=1), a_busy = b_busy = hazard = 0. Deassertion is sampled on clk; the first write takes effect on the first rising edge with reset_n=1.
- Write: on posedge clk with write=1, R[writenum] <= data_in. No effect on other registers. Write latency is 1 cycle to storage.
- Read: a_out = R[anum], b_out = R[bnum], purely combinational, 0-cycle latency.
  - Both ports may address the same register.
  - Any index is legal; no default/zero case.
- Bypass (BYPASS=1): if write=1 and writenum==anum, a_out = data_in and a_busy = 0 in the same cycle. Port B behaves the same way. With BYPASS=0, the old value and busy status are shown until the edge.
- Scoreboard update at each posedge, evaluated in priority order:
  1. flush=1: busy_vec <= 0 (overrides lock and write clear).
  2. Otherwise, per bit i: set if lock=1 and locknum==i; else clear if write=1 and writenum==i; else hold.
  - lock and write to the same index in the same cycle: busy stays/becomes 1 (new producer wins); data is still written.
  - Locking an already-busy register: stays 1, no counting (single outstanding producer per register).
  - Write to a non-busy register: legal; busy stays 0.
- a_busy = busy_vec[anum] (subject to bypass masking); b_busy is the same for bnum; hazard = a_busy | b_busy.
- flush with write in the same cycle: data is written, all busy bits cleared.
- Reset mid-operation: all state clears immediately regardless of clk, and pending locks are discarded.
- No X-propagation sources: every register and busy bit has a reset value.

Test Plan:
- Reset then read: assert reset_n=0 asynchronously between edges, anum=5, bnum=7 -> a_out=0, b_out=0, busy_vec=0 immediately, without waiting for an edge.
- Write/read all: write R[i]=16'h1111*i for i=0..7 over 8 cycles, then sweep anum/bnum -> each port returns 16'h1111*i one cycle after its write; all other registers unchanged.
- Bypass: BYPASS=1, R3=16'hAAAA, write=1, writenum=3, data_in=16'h5A5A, anum=3 -> a_out=16'h5A5A in the same cycle. Repeat with BYPASS=0 -> a_out=16'hAAAA until the edge, then 16'h5A5A.
- Scoreboard: lock R2, next cycle anum=2 -> a_busy=1, hazard=1. Write R2=16'h0042 -> after the edge busy_vec[2]=0, a_out=16'h0042, hazard=0.
- Simultaneous lock+write on R4 with data_in=16'h00FF -> after the edge R4=16'h00FF, busy_vec[4]=1.
- Flush: lock R1, R6, R7; then flush=1 with write R1=16'h0009 -> after the edge busy_vec=8'h00, R1=16'h0009. Separately, parametrise WIDTH=32, AW=4: write R15=32'hDEADBEEF -> b_out=32'hDEADBEEF with bnum=15.
